// File: rtl/gpio_in_capture.sv
// gpio_in_capture
//   Memory-mapped 8-bit input port on the dmem bus. Each pin is brought into
//   the clk domain with a two-flop synchroniser. It is then debounced by a
//   per-pin stable-cycle counter. Accepted level changes latch sticky rise or
//   fall flags. Enabled flags drive a registered level interrupt.
//
//   Register map (word-aligned base; dmem_addr[0] picks the byte lane):
//     BASE+0/1  R   {8'd0, level}
//     BASE+2/3  RW  {fall_flags, rise_flags}   write-1-to-clear
//     BASE+4/5  RW  {fall_en, rise_en}
//   Any other address reads 0, and writes to it are ignored.
//
// Ports:
//   clk, rst    single clock, synchronous active-high reset
//   gpio_in     asynchronous external pins
//   dmem_*      bus address, write strobe, byte/word select, write data
//   dmem_rdata  registered read data, valid the cycle after the address
//   irq         registered level interrupt
module gpio_in_capture #(
  parameter int          ADDR_WIDTH      = 16,
  parameter int unsigned BASE_ADDR       = 'h084,
  parameter int          DB_WIDTH        = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            gpio_in,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic                  dmem_wen,
  input  logic                  dmem_byt,
  input  logic [15:0]           dmem_wdata,
  output logic [15:0]           dmem_rdata,
  output logic                  irq
);

  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] SPAN     = ADDR_WIDTH'(6);
  localparam logic [DB_WIDTH-1:0]   CNT_LAST = DB_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    REG_LEVEL = 2'd0,
    REG_FLAGS = 2'd1,
    REG_EN    = 2'd2,
    REG_NONE  = 2'd3
  } reg_sel_e;

  logic [7:0]          sync1_q, sync1_d;
  logic [7:0]          sync2_q, sync2_d;
  logic [7:0]          level_q, level_d;
  logic [DB_WIDTH-1:0] cnt_q [8];
  logic [DB_WIDTH-1:0] cnt_d [8];
  logic [7:0]          rise_flags_q, rise_flags_d;
  logic [7:0]          fall_flags_q, fall_flags_d;
  logic [7:0]          rise_en_q, rise_en_d;
  logic [7:0]          fall_en_q, fall_en_d;
  logic [15:0]         rdata_q, rdata_d;
  logic                irq_q, irq_d;

  logic [ADDR_WIDTH-1:0] offset;
  reg_sel_e              sel;
  logic                  lo_wr, hi_wr;
  logic [7:0]            set_rise, set_fall;
  logic [7:0]            clr_rise, clr_fall;

  // Address decode: subtracting the base lets one unsigned compare cover the
  // whole six-byte window, and the result also wraps addresses below BASE out.
  always_comb begin
    offset = dmem_addr - BASE;
    sel    = REG_NONE;
    if (offset < SPAN) begin
      unique case (offset[2:1])
        2'd0:    sel = REG_LEVEL;
        2'd1:    sel = REG_FLAGS;
        2'd2:    sel = REG_EN;
        default: sel = REG_NONE;
      endcase
    end
    // The low lane is written only by even addresses. The high lane is written
    // by odd addresses, or by a word write at the even address.
    lo_wr = dmem_wen && !dmem_addr[0];
    hi_wr = dmem_wen && (dmem_addr[0] || !dmem_byt);
  end

  // Synchroniser and per-pin debounce
  always_comb begin
    sync1_d  = gpio_in;
    sync2_d  = sync1_q;
    level_d  = level_q;
    set_rise = '0;
    set_fall = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        level_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
        if (sync2_q[i]) begin
          set_rise[i] = 1'b1;
        end else begin
          set_fall[i] = 1'b1;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + DB_WIDTH'(1);
      end
    end
  end

  // Register updates, read mux and interrupt
  always_comb begin
    clr_rise  = '0;
    clr_fall  = '0;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;

    if (sel == REG_FLAGS) begin
      if (lo_wr) clr_rise = dmem_wdata[7:0];
      if (hi_wr) clr_fall = dmem_wdata[15:8];
    end
    if (sel == REG_EN) begin
      if (lo_wr) rise_en_d = dmem_wdata[7:0];
      if (hi_wr) fall_en_d = dmem_wdata[15:8];
    end

    // Set is OR-ed after the clear, so a new event wins over a same-cycle W1C.
    rise_flags_d = (rise_flags_q & ~clr_rise) | set_rise;
    fall_flags_d = (fall_flags_q & ~clr_fall) | set_fall;

    irq_d = |((rise_flags_d & rise_en_d) | (fall_flags_d & fall_en_d));

    unique case (sel)
      REG_LEVEL: rdata_d = {8'h00, level_q};
      REG_FLAGS: rdata_d = {fall_flags_q, rise_flags_q};
      REG_EN:    rdata_d = {fall_en_q, rise_en_q};
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      cnt_q        <= '{default: '0};
      rise_flags_q <= '0;
      fall_flags_q <= '0;
      rise_en_q    <= '0;
      fall_en_q    <= '0;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      rise_flags_q <= rise_flags_d;
      fall_flags_q <= fall_flags_d;
      rise_en_q    <= rise_en_d;
      fall_en_q    <= fall_en_d;
      rdata_q      <= rdata_d;
      irq_q        <= irq_d;
    end
  end

  assign dmem_rdata = rdata_q;
  assign irq        = irq_q;

endmodule

// File: doc/gpio_in_capture.md
Name: gpio_in_capture

Overview:
- Memory-mapped 8-bit general-purpose input port. It is the read-side counterpart of the board's GPIO output register.
- Synchronises and debounces eight external pins and latches sticky rise/fall event flags.
- Raises a level interrupt to the CPU.
- Sits on the dmem bus beside the LED/LCD/GPIO output registers. Its read data is OR-merged into the board's io read mux.

Parameters:
- ADDR_WIDTH, 16: width of dmem_addr.
- BASE_ADDR, 'h084: word-aligned base address; the block decodes BASE_ADDR..BASE_ADDR+5.
- DB_WIDTH, 16: width of each per-pin debounce counter.
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles required to accept a new level; legal range 1..2^DB_WIDTH-1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- gpio_in  in  8  asynchronous external pins.
- dmem_addr  in  ADDR_WIDTH  bus address.
- dmem_wen  in  1  write strobe, one cycle per write.
- dmem_byt  in  1  1 = byte write, 0 = word write.
- dmem_wdata  in  16  write data.
- dmem_rdata  out  16  registered read data; 0 when the address is unmapped.
- irq  out  1  level interrupt, registered.

Behaviour:
- Reset, sampled on a clk edge while rst=1: all of the following go to 0 — sync stages, level, counters, rise_flags, fall_flags, rise_en, fall_en, dmem_rdata, irq.
- Synchroniser: two-flop chain per pin, giving sync[i].
- Debounce, per bit i:
  - If sync[i]==level[i]: cnt[i] <= 0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: level[i] <= sync[i], cnt[i] <= 0, and set rise_flags[i] (when sync=1) or fall_flags[i] (when sync=0).
  - Else: cnt[i] <= cnt[i]+1.
  - A pin change held steady becomes visible in level 2+DEBOUNCE_CYCLES cycles after the first clk edge that samples it.
  - A glitch shorter than DEBOUNCE_CYCLES produces no level change and no flag.
- Register map (dmem_addr[0] selects the byte lane; reads return the whole word for either address):
  - BASE+0/1, read: {8'd0, level}. Writes are ignored.
  - BASE+2/3, read: {fall_flags, rise_flags}. Writes are write-1-to-clear:
    - word write at BASE+2 clears rise with wdata[7:0] and fall with wdata[15:8];
    - byte write at BASE+2 clears rise with wdata[7:0] only;
    - any write at BASE+3 clears fall with wdata[15:8].
  - BASE+4/5, read: {fall_en, rise_en}. Writes use the same lane rules as BASE+2/3, but store the value instead of clearing.
  - All other addresses: read 0; writes have no effect.
- Read timing:
  - dmem_rdata <= mux(dmem_addr) on every edge, so data is valid the cycle after the address is presented.
  - The mux reflects register values before that same edge's updates.
  - Reads have no side effects.
- Simultaneous flag set and W1C on the same bit in the same cycle: the set wins and the flag stays 1. W1C on other bits is unaffected.
- irq <= |((rise_flags & rise_en) | (fall_flags & fall_en)), computed from the post-update register values. irq is therefore 1 in the cycle after a flag or enable change.
- Reset mid-debounce discards counter progress. A pin held high through reset release produces level=1 and a rise flag 2+DEBOUNCE_CYCLES cycles after release, because the initial level is 0.
- Counters never wrap, since they reset at the DEBOUNCE_CYCLES-1 threshold.

Test Plan (DEBOUNCE_CYCLES=4, BASE_ADDR='h084):
- Reset check: hold rst 3 cycles with gpio_in=8'h00, then read 'h084, 'h086, 'h088 -> each dmem_rdata=16'h0000; irq=0 throughout.
- Debounce and level: drive gpio_in=8'h05 steady -> level reads 16'h0005 at exactly cycle 6 after the change; 'h086 reads 16'h0005. A 3-cycle pulse of bit 7 -> level and flags unchanged.
- Falling edge and W1C: with rise_flags=8'h05, drive gpio_in=8'h01, wait 6 cycles -> 'h086 reads 16'h0405. Word write 16'h0401 to 'h086 -> reads 16'h0004. Byte write (byt=1) 8'h04 to 'h086 -> reads 16'h0000.
- Interrupt: write 16'h0100 to 'h088 (fall_en bit0); drive bit0 1->0 -> irq=1 the cycle after fall_flags[0] sets. Byte write to 'h087 with wdata[15:8]=8'h01 -> irq=0 the next cycle.
- Set/clear collision: schedule a W1C of rise bit3 on the same edge that rise_flags[3] sets -> flag reads 1 afterwards.
- Decode: write 16'hFFFF to 'h084 and 'h08A -> no register changes; reads of 'h08A and 'h083 return 16'h0000.
